// File: rtl/pmod_pkg.sv
// pmod_pkg: shared FSM states, size/response codes and strobe helpers for the pmod bus master
package pmod_pkg;
    typedef enum logic [2:0] {IDLE, WREQ, WRESP, RREQ, RRESP} state_e;
    localparam logic [2:0] SZ_BURST = 3'b000;
    localparam logic [2:0] SZ_1B = 3'b001;
    localparam logic [2:0] SZ_2B = 3'b010;
    localparam logic [2:0] SZ_4B = 3'b100;
    localparam logic [2:0] SZ_8B = 3'b110;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // 11x is 8 bytes; anything not listed (burst included) yields an empty mask
    function automatic logic [7:0] size_mask(input logic [2:0] len);
        return len[2:1] == 2'b11 ? 8'hFF : len == SZ_4B ? 8'h0F : len == SZ_2B ? 8'h03 :
               len == SZ_1B ? 8'h01 : 8'h00;
    endfunction

    function automatic logic [7:0] size_to_strb(input logic [2:0] len, input logic [2:0] addr);
        return size_mask(len) << addr;
    endfunction

    function automatic logic req_legal(input logic [2:0] len, input logic [2:0] addr);
        logic [2:0] amask;
        amask = len[2:1] == 2'b11 ? 3'b111 : len == SZ_4B ? 3'b011 : len == SZ_2B ? 3'b001 : 3'b000;
        return size_mask(len) != 8'h00 && (addr & amask) == 3'b000;
    endfunction
endpackage

// File: rtl/pmod_bus_master.sv
// pmod_bus_master: runs one decoded single-beat request as a 64-bit AXI4-Lite-style transaction
module pmod_bus_master
    import pmod_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                write_req,
    input  logic                read_req,
    input  logic [9:0]          len,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    output logic                busy,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddr,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                rdata_valid,
    output logic [1:0]          resp_o,
    output logic                err,
    input  logic                err_clear
);
    state_e state_q, state_d;
    logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic bready_q, bready_d, rready_q, rready_d, busy_q, busy_d;
    logic rvld_q, rvld_d, err_q, err_d, err_set, legal;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [1:0] resp_q, resp_d;
    logic unused_len;

    assign unused_len = ^len[9:3];
    assign legal = req_legal(len[2:0], address[2:0]);

    always_comb begin
        state_d = state_q;
        awvalid_d = awvalid_q;
        wvalid_d = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d = bready_q;
        rready_d = rready_q;
        busy_d = busy_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        resp_d = resp_q;
        rvld_d = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: if (write_req || read_req) begin
                err_set = !legal || (write_req && read_req);
                if (legal) begin
                    addr_d = address;
                    busy_d = 1'b1;
                    if (write_req) begin
                        wdata_d = wdata;
                        wstrb_d = size_to_strb(len[2:0], address[2:0]);
                        awvalid_d = 1'b1;
                        wvalid_d = 1'b1;
                        state_d = WREQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d = RREQ;
                    end
                end
            end
            // each valid drops on its own handshake; WRESP is entered once both have dropped
            WREQ: begin
                if (awvalid_q && awready) awvalid_d = 1'b0;
                if (wvalid_q && wready) wvalid_d = 1'b0;
                if (!awvalid_q && !wvalid_q) begin
                    bready_d = 1'b1;
                    state_d = WRESP;
                end
            end
            WRESP: if (bvalid && bready_q) begin
                resp_d = bresp;
                bready_d = 1'b0;
                busy_d = 1'b0;
                err_set = bresp != OKAY;
                state_d = IDLE;
            end
            RREQ: if (arready) begin
                arvalid_d = 1'b0;
                rready_d = 1'b1;
                state_d = RRESP;
            end
            RRESP: if (rvalid && rready_q) begin
                rdata_d = rdata;
                resp_d = rresp;
                rvld_d = 1'b1;
                rready_d = 1'b0;
                busy_d = 1'b0;
                err_set = rresp != OKAY;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && (write_req || read_req)) err_set = 1'b1;
        err_d = err_set || (err_q && !err_clear);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q <= 1'b0;
            rready_q <= 1'b0;
            busy_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            resp_q <= OKAY;
            rvld_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q <= bready_d;
            rready_q <= rready_d;
            busy_q <= busy_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            resp_q <= resp_d;
            rvld_q <= rvld_d;
            err_q <= err_d;
        end
    end

    assign busy = busy_q;
    assign awvalid = awvalid_q;
    assign wvalid = wvalid_q;
    assign arvalid = arvalid_q;
    assign bready = bready_q;
    assign rready = rready_q;
    assign awaddr = addr_q;
    assign araddr = addr_q;
    assign wdata_o = wdata_q;
    assign wstrb = wstrb_q;
    assign rdata_o = rdata_q;
    assign resp_o = resp_q;
    assign rdata_valid = rvld_q;
    assign err = err_q;
endmodule

// File: tb/tb_pmod_bus_master.sv
// tb_pmod_bus_master: scoreboard bench with a configurable-latency bus slave
module tb_pmod_bus_master;
    logic clk = 1'b0, reset = 1'b0;
    logic write_req = 1'b0, read_req = 1'b0, err_clear = 1'b0;
    logic [9:0] len = '0;
    logic [31:0] address = '0;
    logic [63:0] wdata = '0;
    logic busy, awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, araddr;
    logic [63:0] wdata_o, rdata, rdata_o;
    logic [7:0] wstrb;
    logic [1:0] bresp, rresp, resp_o;
    logic rdata_valid, err;

    int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
    int aw_cnt, w_cnt, ar_cnt, r_cnt;
    logic aw_seen, w_seen, r_pend, b_hold = 1'b0;
    logic [63:0] r_data = '0;
    logic [1:0] r_resp = 2'b00, b_resp_cfg = 2'b00;

    logic [31:0] exp_aw[$];
    logic [71:0] exp_w[$];
    logic [31:0] exp_ar[$];
    logic [65:0] exp_r[$];
    int n_tests = 0, n_fail = 0, b_cnt = 0, n, b0;

    pmod_bus_master dut (
        .clk(clk), .reset(reset), .write_req(write_req), .read_req(read_req), .len(len),
        .address(address), .wdata(wdata), .busy(busy), .awvalid(awvalid), .awready(awready),
        .awaddr(awaddr), .wvalid(wvalid), .wready(wready), .wdata_o(wdata_o), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .arvalid(arvalid), .arready(arready),
        .araddr(araddr), .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rdata_o(rdata_o), .rdata_valid(rdata_valid), .resp_o(resp_o), .err(err), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    assign awready = awvalid && aw_cnt >= aw_dly;
    assign wready = wvalid && w_cnt >= w_dly;
    assign arready = arvalid && ar_cnt >= ar_dly;
    assign rdata = r_data;
    assign rresp = r_resp;
    assign bresp = b_resp_cfg;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            aw_cnt <= 0;
            w_cnt <= 0;
            ar_cnt <= 0;
            r_cnt <= 0;
            aw_seen <= 1'b0;
            w_seen <= 1'b0;
            r_pend <= 1'b0;
            bvalid <= 1'b0;
            rvalid <= 1'b0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt <= (wvalid && !wready) ? w_cnt + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (awvalid && awready) aw_seen <= 1'b1;
            if (wvalid && wready) w_seen <= 1'b1;
            if (!bvalid && !b_hold && (aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready))) begin
                bvalid <= 1'b1;
                aw_seen <= 1'b0;
                w_seen <= 1'b0;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin
                if (r_dly == 0) rvalid <= 1'b1;
                else begin
                    r_pend <= 1'b1;
                    r_cnt <= r_dly;
                end
            end
            if (r_pend) begin
                if (r_cnt == 1) begin
                    rvalid <= 1'b1;
                    r_pend <= 1'b0;
                end else r_cnt <= r_cnt - 1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bus-side scoreboard; per-cycle address/data compares also cover stability while stalled
    always @(negedge clk) begin
        if (reset) begin
            if (awvalid) begin
                check("aw_expected", exp_aw.size() != 0, 1'b1);
                if (exp_aw.size() != 0) begin
                    check("awaddr", awaddr, exp_aw[0]);
                    if (awready) void'(exp_aw.pop_front());
                end
            end
            if (wvalid) begin
                check("w_expected", exp_w.size() != 0, 1'b1);
                if (exp_w.size() != 0) begin
                    check("wstrb_wdata", {wstrb, wdata_o}, exp_w[0]);
                    if (wready) void'(exp_w.pop_front());
                end
            end
            if (arvalid) begin
                check("ar_expected", exp_ar.size() != 0, 1'b1);
                if (exp_ar.size() != 0) begin
                    check("araddr", araddr, exp_ar[0]);
                    if (arready) void'(exp_ar.pop_front());
                end
            end
            if (rdata_valid) begin
                check("r_expected", exp_r.size() != 0, 1'b1);
                if (exp_r.size() != 0) check("resp_rdata", {resp_o, rdata_o}, exp_r.pop_front());
            end
            if (bvalid && bready) b_cnt++;
        end
    end

    task automatic req(input logic w, input logic r, input logic [31:0] a, input logic [2:0] l, input logic [63:0] d);
        @(negedge clk);
        write_req = w;
        read_req = r;
        address = a;
        len = {7'd0, l};
        wdata = d;
        @(posedge clk);
        #1;
        write_req = 1'b0;
        read_req = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] l, input logic [63:0] d, input logic [7:0] s);
        exp_aw.push_back(a);
        exp_w.push_back({s, d});
        req(1'b1, 1'b0, a, l, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] l, input logic [63:0] d, input logic [1:0] rs);
        r_data = d;
        r_resp = rs;
        exp_ar.push_back(a);
        exp_r.push_back({rs, d});
        req(1'b0, 1'b1, a, l, 64'd0);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (busy && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("busy_done", busy, 1'b0);
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        check("err_clear", err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {busy, awvalid, wvalid, arvalid, bready, rready, rdata_valid, err}, 8'h00);
        check("rst_data", {rdata_o, resp_o, wstrb}, '0);
        check("rst_addr", {awaddr, araddr, wdata_o}, '0);
        @(negedge clk);
        reset = 1'b1;

        wr(32'h1000_0004, 3'b100, 64'h1122_3344_0000_0000, 8'hF0);
        wait_done(n);
        check("w4_latency", n, 4);
        check("w4_resp", resp_o, 2'b00);
        check("w4_err", err, 1'b0);
        check("w4_bcnt", b_cnt, 1);

        aw_dly = 3;
        b0 = b_cnt;
        wr(32'h3000_0008, 3'b110, 64'hA5A5_0F0F_1234_5678, 8'hFF);
        check("awdly_v1", {awvalid, wvalid}, 2'b11);
        @(posedge clk);
        #1;
        check("awdly_v2", {awvalid, wvalid}, 2'b10);
        wait_done(n);
        repeat (2) @(posedge clk);
        check("awdly_bcnt", b_cnt - b0, 1);
        aw_dly = 0;

        r_dly = 2;
        rd(32'h2000_0000, 3'b110, 64'hDEAD_BEEF_0123_4567, 2'b00);
        wait_done(n);
        check("r8_latency", n, 5);
        check("r8_rvalid_at_fall", rdata_valid, 1'b1);
        @(posedge clk);
        #1;
        check("r8_rvalid_pulse", rdata_valid, 1'b0);
        r_dly = 0;

        rd(32'h0000_0044, 3'b100, 64'h0BAD_F00D_CAFE_0001, 2'b00);
        wait_done(n);
        check("r0_latency", n, 3);

        req(1'b1, 1'b0, 32'h0000_0003, 3'b010, 64'h1);
        check("misal_busy", {busy, awvalid, wvalid}, 3'b000);
        check("misal_err", err, 1'b1);
        repeat (3) @(posedge clk);
        clear_err();

        req(1'b0, 1'b1, 32'h0000_0100, 3'b000, 64'h0);
        check("burst_busy", {busy, arvalid}, 2'b00);
        check("burst_err", err, 1'b1);
        clear_err();

        @(negedge clk);
        write_req = 1'b1;
        address = 32'h0000_0005;
        len = 10'b100;
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        write_req = 1'b0;
        err_clear = 1'b0;
        check("clr_vs_new_err", err, 1'b1);
        clear_err();

        r_dly = 3;
        rd(32'h5000_0010, 3'b110, 64'hFEED_FACE_0BAD_C0DE, 2'b00);
        req(1'b1, 1'b0, 32'h6000_0000, 3'b110, 64'h77);
        check("busyreq_err", err, 1'b1);
        check("busyreq_busy", busy, 1'b1);
        wait_done(n);
        check("busyreq_rvalid", rdata_valid, 1'b1);
        r_dly = 0;
        clear_err();

        exp_aw.push_back(32'h0000_0010);
        exp_w.push_back({8'h0F, 64'h0000_0000_CAFE_BABE});
        req(1'b1, 1'b1, 32'h0000_0010, 3'b100, 64'h0000_0000_CAFE_BABE);
        check("both_err", err, 1'b1);
        wait_done(n);
        check("both_latency", n, 4);
        clear_err();

        b_resp_cfg = 2'b10;
        wr(32'h0000_0022, 3'b010, 64'h0000_0000_BEEF_0000, 8'h0C);
        wait_done(n);
        check("slverr_resp", resp_o, 2'b10);
        check("slverr_err", err, 1'b1);
        b_resp_cfg = 2'b00;
        clear_err();

        b_hold = 1'b1;
        b0 = b_cnt;
        wr(32'h7000_0000, 3'b110, 64'h0123_4567_89AB_CDEF, 8'hFF);
        for (int i = 0; i < 20 && !bready; i++) begin
            @(posedge clk);
            #1;
        end
        check("wresp_reached", bready, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_ctrl", {busy, awvalid, wvalid, arvalid, bready, rready, rdata_valid, err}, 8'h00);
        check("arst_data", {rdata_o, resp_o, wstrb}, '0);
        check("arst_addr", {awaddr, araddr, wdata_o}, '0);
        b_hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("arst_no_b", b_cnt - b0, 0);

        wr(32'h7000_0007, 3'b001, 64'h5A00_0000_0000_0000, 8'h80);
        wait_done(n);
        check("b1_latency", n, 4);
        check("b1_resp", resp_o, 2'b00);

        repeat (3) @(posedge clk);
        check("sb_empty", exp_aw.size() + exp_w.size() + exp_ar.size() + exp_r.size(), 0);
        check("b_total", b_cnt, 5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pmod_bus_master.md
Name: pmod_bus_master

Overview:
- Downstream stage of the pmod command decoder.
- Takes a decoded single-beat request (write_req/read_req pulse with len, address, wdata) and executes it as one 64-bit AXI4-Lite-style transaction on the on-chip bus.
- Computes byte strobes from the address and size, and reports busy back to the decoder.
- Returns read data and response status for the upstream serializer to send back to the pico.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 64, bus data width; fixed at 64 (strobe logic assumes 8 lanes).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- write_req  in  1  one-cycle pulse: start write.
- read_req  in  1  one-cycle pulse: start read.
- len  in  10  size code; [2:0]: 001=1B, 010=2B, 100=4B, 11x=8B, 000=burst (unsupported).
- address  in  32  byte address.
- wdata  in  64  write data, already lane-aligned.
- busy  out  1  high from request acceptance through response completion.
- awvalid/awready/awaddr  out/in/out  1/1/32  write address channel.
- wvalid/wready/wdata_o/wstrb  out/in/out/out  1/1/64/8  write data channel.
- bvalid/bready/bresp  in/out/in  1/1/2  write response channel.
- arvalid/arready/araddr  out/in/out  1/1/32  read address channel.
- rvalid/rready/rdata/rresp  in/out/in/in  1/1/64/2  read data channel.
- rdata_o  out  64  captured read data.
- rdata_valid  out  1  one-cycle pulse when rdata_o and resp_o are updated by a read.
- resp_o  out  2  last bresp/rresp.
- err  out  1  sticky error flag.
- err_clear  in  1  synchronous clear for err.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All valid outputs 0; bready=0, rready=0, busy=0.
  - rdata_o=0, resp_o=0, rdata_valid=0, err=0.
  - awaddr, araddr, wdata_o, wstrb = 0.
- Reset mid-transaction: drop to IDLE immediately. No completion pulse is produced.
- States: IDLE, WREQ, WRESP, RREQ, RRESP.
- IDLE:
  - On write_req: latch addresses, data and strobe. Assert awvalid, wvalid, busy on the next cycle; go to WREQ.
  - On read_req: assert arvalid, busy; go to RREQ.
  - Both pulses in the same cycle: write wins; set err.
- Request rejection (no transaction issued, err set, busy unchanged):
  - Misaligned request: address[2:0] not a multiple of size.
  - Burst code 000.
  - Request arriving while busy=1.
- Strobe: size mask shifted left by address[2:0]. 1B=8'h01, 2B=8'h03, 4B=8'h0F, 8B=8'hFF. Example: address[2:0]=4, 4B gives 8'hF0.
- awaddr/araddr: equal to address (not truncated). wdata_o passes latched wdata unmodified.
- WREQ:
  - awvalid and wvalid each drop independently on the cycle after their own ready handshake.
  - awvalid and wvalid hold stable until accepted (AXI rules).
  - When both handshakes are done, go to WRESP with bready=1.
- WRESP:
  - On bvalid&bready: resp_o<=bresp; bready<=0; busy<=0; go to IDLE.
  - If bresp!=0, set err.
- RREQ: on arready, drop arvalid; set rready=1; go to RRESP.
- RRESP:
  - On rvalid&rready: rdata_o<=rdata; resp_o<=rresp; pulse rdata_valid; rready<=0; busy<=0; go to IDLE.
  - If rresp!=0, set err.
- Latency with zero-wait slave:
  - Write: request to busy fall = 4 cycles.
  - Read: request to busy fall and rdata_valid pulse = 3 cycles.
- New request accepted the cycle after busy falls.
- err_clear coinciding with a new error: the error wins (err stays 1).

Decomposition:
- Package pmod_pkg:
  - State enum.
  - Size-code constants (SZ_1B, SZ_2B, SZ_4B, SZ_8B, SZ_BURST).
  - AXI response constants (OKAY=2'b00, SLVERR=2'b10).
  - Function size_to_strb(len[2:0], addr[2:0]).
- No sub-module; strobe generation is a package function.

Test Plan:
- Aligned 4B write, len=3'b100, address=32'h1000_0004, wdata=64'h1122_3344_0000_0000, zero-wait slave -> awaddr=32'h1000_0004, wstrb=8'hF0, busy high 4 cycles, resp_o=0, err=0.
- Write with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle; awvalid holds with stable awaddr until accepted; a single bready handshake follows.
- 8B read at address=32'h2000_0000, slave returns rdata=64'hDEAD_BEEF_0123_4567 after 2 wait cycles -> rdata_valid pulses once with that value, busy falls the same cycle.
- Misaligned request: 2B write at address[2:0]=3 -> no awvalid/wvalid, err=1, busy stays 0; err_clear -> err=0.
- write_req pulse during an outstanding read -> ignored, err=1, the read completes normally; then a slave bresp=2'b10 on a later write -> resp_o=2'b10, err=1.
- Assert reset mid-WRESP -> all outputs at reset values asynchronously; after release, a 1B write at address[2:0]=7 gives wstrb=8'h80.
